// File: rtl/imem_fetch_ctrl_if.sv
// Bundles the instruction-memory bus and the CPU-facing fetch signals of the
// fetch controller; master is the controller side, slave is the environment.
interface imem_fetch_ctrl_if;
   logic        mem_read;
   logic [31:0] mem_address;
   logic [31:0] mem_readdata;
   logic        mem_busywait;
   logic        ins_ready;
   logic [31:0] instruction;
   logic [31:0] pc_out;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        fault;

   modport master (
      output mem_read, mem_address, ins_ready, instruction, pc_out, fault,
      input  mem_readdata, mem_busywait, stall, branch_taken, branch_target
   );

   modport slave (
      input  mem_read, mem_address, ins_ready, instruction, pc_out, fault,
      output mem_readdata, mem_busywait, stall, branch_taken, branch_target
   );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: prefetches into a 2-entry {pc, instr} FIFO,
// handles branch redirects (draining a busy request) and a memory-timeout fault.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [7:0]  TIMEOUT  = 8'd255
) (
   input logic              clk,
   input logic              reset,
   imem_fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

   state_t      state;
   logic [31:0] fetch_pc;
   logic [31:0] redirect_pc;
   logic [31:0] fifo_pc    [2];
   logic [31:0] fifo_instr [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic        req_active;
   logic [7:0]  wait_cnt;
   logic        fault;

   logic        mem_read;
   logic        ins_ready;
   logic        completion;
   logic        stalled;
   logic        pop;
   logic        timeout_hit;
   logic [31:0] target;

   always_comb begin
      mem_read    = ((state == RUN) && ((count < 2'd2) || req_active)) || (state == DRAIN);
      ins_ready   = (state == RUN) && (count != 2'd0);
      completion  = mem_read && !bus.mem_busywait;
      stalled     = mem_read && bus.mem_busywait;
      pop         = ins_ready && !bus.stall;
      timeout_hit = stalled && (({1'b0, wait_cnt} + 9'd1) >= {1'b0, TIMEOUT});
      target      = bus.branch_target & 32'hFFFF_FFFC;
   end

   assign bus.mem_read    = mem_read;
   assign bus.mem_address = fetch_pc;
   assign bus.ins_ready   = ins_ready;
   assign bus.instruction = fifo_instr[rd_ptr];
   assign bus.pc_out      = fifo_pc[rd_ptr];
   assign bus.fault       = fault;

   // fetch_pc is the address on the bus; during DRAIN it holds the abandoned
   // request's address while redirect_pc collects the latest branch target.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= RUN;
         fetch_pc      <= RESET_PC & 32'hFFFF_FFFC;
         redirect_pc   <= 32'h0;
         fifo_pc[0]    <= 32'h0;
         fifo_pc[1]    <= 32'h0;
         fifo_instr[0] <= 32'h0;
         fifo_instr[1] <= 32'h0;
         rd_ptr        <= 1'b0;
         wr_ptr        <= 1'b0;
         count         <= 2'd0;
         req_active    <= 1'b0;
         wait_cnt      <= 8'd0;
         fault         <= 1'b0;
      end else begin
         if (stalled)
            wait_cnt <= wait_cnt + 8'd1;
         else if (completion)
            wait_cnt <= 8'd0;

         if (timeout_hit) begin
            state      <= HALT;
            fault      <= 1'b1;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            req_active <= 1'b0;
         end else begin
            case (state)
               RUN: begin
                  req_active <= stalled;
                  if (bus.branch_taken) begin
                     count  <= 2'd0;
                     rd_ptr <= 1'b0;
                     wr_ptr <= 1'b0;
                     if (stalled) begin
                        state       <= DRAIN;
                        redirect_pc <= target;
                     end else begin
                        fetch_pc <= target;
                     end
                  end else begin
                     if (completion) begin
                        fifo_pc[wr_ptr]    <= fetch_pc;
                        fifo_instr[wr_ptr] <= bus.mem_readdata;
                        wr_ptr             <= ~wr_ptr;
                        fetch_pc           <= fetch_pc + 32'd4;
                     end
                     if (pop)
                        rd_ptr <= ~rd_ptr;
                     case ({completion, pop})
                        2'b10:   count <= count + 2'd1;
                        2'b01:   count <= count - 2'd1;
                        default: count <= count;
                     endcase
                  end
               end
               DRAIN: begin
                  // a redirect arriving on the draining completion edge still wins
                  if (completion) begin
                     state      <= RUN;
                     req_active <= 1'b0;
                     fetch_pc   <= bus.branch_taken ? target : redirect_pc;
                  end else if (bus.branch_taken) begin
                     redirect_pc <= target;
                  end
               end
               HALT: begin
                  state <= HALT;
               end
               default: begin
                  state <= HALT;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus a randomized
// run checked against an in-order program-stream model with branch redirects.
module tb_imem_fetch_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   imem_fetch_ctrl_if bus ();

   imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(8'd4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // The memory image: three fixed words at the start, a hash of the address elsewhere.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0090_0093;
         32'h4:   return 32'h0050_0113;
         32'h8:   return 32'h0020_8333;
         default: return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
      endcase
   endfunction

   assign bus.mem_readdata = word_at(bus.mem_address);

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      bus.stall = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_target = 32'h0;
      bus.mem_busywait = 1'b0;
      step;
      step;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      vectors++; if (bus.ins_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ins_ready: got %b want 0", bus.ins_ready); end
      vectors++; if (bus.instruction !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_instruction: got %h want 0", bus.instruction); end
      vectors++; if (bus.pc_out !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc_out: got %h want 0", bus.pc_out); end
      vectors++; if (bus.fault !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fault: got %b want 0", bus.fault); end
      vectors++; if (bus.mem_read !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_mem_read: got %b want 1", bus.mem_read); end
      vectors++; if (bus.mem_address !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_address: got %h want 0", bus.mem_address); end
   endtask

   task automatic test_sequential;
      logic [31:0] exp_pc;
      do_reset;
      for (int i = 0; i < 3; i++) begin
         step;
         exp_pc = 32'(i * 4);
         vectors++; if (bus.ins_ready !== 1'b1 || bus.pc_out !== exp_pc) begin miscompares++; $display("[TB] FAIL seq_pc%0d: got rdy=%b pc=%h want rdy=1 pc=%h", i, bus.ins_ready, bus.pc_out, exp_pc); end
         vectors++; if (bus.instruction !== word_at(exp_pc)) begin miscompares++; $display("[TB] FAIL seq_instr%0d: got %h want %h", i, bus.instruction, word_at(exp_pc)); end
      end
   endtask

   task automatic test_stall;
      do_reset;
      bus.stall = 1'b1;
      repeat (5) step;
      vectors++; if (bus.mem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_mem_read: got %b want 0", bus.mem_read); end
      vectors++; if (bus.ins_ready !== 1'b1 || bus.pc_out !== 32'h0) begin miscompares++; $display("[TB] FAIL stall_head: got rdy=%b pc=%h want rdy=1 pc=0", bus.ins_ready, bus.pc_out); end
      bus.stall = 1'b0;
      step;
      vectors++; if (bus.pc_out !== 32'h4 || bus.instruction !== word_at(32'h4)) begin miscompares++; $display("[TB] FAIL stall_second: got pc=%h want pc=4", bus.pc_out); end
      vectors++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h8) begin miscompares++; $display("[TB] FAIL stall_resume: got rd=%b addr=%h want rd=1 addr=8", bus.mem_read, bus.mem_address); end
      step;
      vectors++; if (bus.ins_ready !== 1'b1 || bus.pc_out !== 32'h8) begin miscompares++; $display("[TB] FAIL stall_third: got rdy=%b pc=%h want rdy=1 pc=8", bus.ins_ready, bus.pc_out); end
   endtask

   task automatic test_branch_busy;
      do_reset;
      repeat (4) step;
      vectors++; if (bus.mem_address !== 32'h10) begin miscompares++; $display("[TB] FAIL bb_setup_addr: got %h want 10", bus.mem_address); end
      bus.mem_busywait = 1'b1;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h22;
      step;
      bus.branch_taken = 1'b0;
      vectors++; if (bus.ins_ready !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_address !== 32'h10) begin miscompares++; $display("[TB] FAIL bb_drain: got rdy=%b rd=%b addr=%h want rdy=0 rd=1 addr=10", bus.ins_ready, bus.mem_read, bus.mem_address); end
      step;
      vectors++; if (bus.ins_ready !== 1'b0 || bus.mem_address !== 32'h10) begin miscompares++; $display("[TB] FAIL bb_drain2: got rdy=%b addr=%h want rdy=0 addr=10", bus.ins_ready, bus.mem_address); end
      step;
      bus.mem_busywait = 1'b0;
      step;
      vectors++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h20 || bus.ins_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bb_target: got rd=%b addr=%h rdy=%b want rd=1 addr=20 rdy=0", bus.mem_read, bus.mem_address, bus.ins_ready); end
      step;
      vectors++; if (bus.ins_ready !== 1'b1 || bus.pc_out !== 32'h20 || bus.instruction !== word_at(32'h20)) begin miscompares++; $display("[TB] FAIL bb_first_pc: got rdy=%b pc=%h want rdy=1 pc=20", bus.ins_ready, bus.pc_out); end
   endtask

   task automatic test_branch_complete;
      do_reset;
      repeat (2) step;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h40;
      step;
      bus.branch_taken = 1'b0;
      vectors++; if (bus.mem_address !== 32'h40 || bus.ins_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bc_target: got addr=%h rdy=%b want addr=40 rdy=0", bus.mem_address, bus.ins_ready); end
      step;
      vectors++; if (bus.pc_out !== 32'h40 || bus.ins_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bc_first_pc: got pc=%h rdy=%b want pc=40 rdy=1", bus.pc_out, bus.ins_ready); end
   endtask

   task automatic test_wrap;
      do_reset;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'hFFFF_FFFE;
      step;
      bus.branch_taken = 1'b0;
      vectors++; if (bus.mem_address !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL wrap_addr: got %h want fffffffc", bus.mem_address); end
      step;
      vectors++; if (bus.pc_out !== 32'hFFFF_FFFC || bus.instruction !== word_at(32'hFFFF_FFFC)) begin miscompares++; $display("[TB] FAIL wrap_head: got pc=%h want fffffffc", bus.pc_out); end
      vectors++; if (bus.mem_address !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap_next: got %h want 0", bus.mem_address); end
   endtask

   task automatic test_timeout;
      do_reset;
      bus.mem_busywait = 1'b1;
      repeat (3) step;
      vectors++; if (bus.fault !== 1'b0 || bus.mem_read !== 1'b1) begin miscompares++; $display("[TB] FAIL to_early: got fault=%b rd=%b want fault=0 rd=1", bus.fault, bus.mem_read); end
      step;
      vectors++; if (bus.fault !== 1'b1 || bus.mem_read !== 1'b0 || bus.ins_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL to_fault: got fault=%b rd=%b rdy=%b want 1 0 0", bus.fault, bus.mem_read, bus.ins_ready); end
      bus.mem_busywait = 1'b0;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h80;
      step;
      bus.branch_taken = 1'b0;
      step;
      vectors++; if (bus.fault !== 1'b1 || bus.mem_read !== 1'b0 || bus.ins_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL to_halt_hold: got fault=%b rd=%b rdy=%b want 1 0 0", bus.fault, bus.mem_read, bus.ins_ready); end
      do_reset;
      vectors++; if (bus.fault !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_address !== 32'h0) begin miscompares++; $display("[TB] FAIL to_reset: got fault=%b rd=%b addr=%h want 0 1 0", bus.fault, bus.mem_read, bus.mem_address); end
      step;
      vectors++; if (bus.ins_ready !== 1'b1 || bus.pc_out !== 32'h0) begin miscompares++; $display("[TB] FAIL to_restart: got rdy=%b pc=%h want rdy=1 pc=0", bus.ins_ready, bus.pc_out); end
   endtask

   // Model: instructions leave in program order from the last redirect target,
   // each carrying the memory word at its pc; a busy request must hold its address.
   task automatic test_random;
      logic [31:0] exp_pc;
      logic [31:0] prev_addr;
      logic [31:0] tgt;
      bit          prev_req;
      int          busy_run;
      int          delivered;
      do_reset;
      exp_pc = 32'h0;
      prev_req = 1'b0;
      prev_addr = 32'h0;
      busy_run = 0;
      delivered = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (prev_req) begin
            vectors++; if (bus.mem_read !== 1'b1 || bus.mem_address !== prev_addr) begin miscompares++; $display("[TB] FAIL rnd_hold@%0d: got rd=%b addr=%h want rd=1 addr=%h", cyc, bus.mem_read, bus.mem_address, prev_addr); end
         end
         bus.stall = ($urandom_range(0, 3) == 0);
         bus.branch_taken = ($urandom_range(0, 24) == 0);
         tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_0FFF);
         bus.branch_target = tgt;
         bus.mem_busywait = (busy_run >= 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
         if (bus.mem_read && bus.mem_busywait) busy_run++;
         else if (bus.mem_read) busy_run = 0;
         if (bus.branch_taken) begin
            exp_pc = tgt & 32'hFFFF_FFFC;
         end else if (bus.ins_ready && !bus.stall) begin
            vectors++; if (bus.pc_out !== exp_pc || bus.instruction !== word_at(exp_pc)) begin miscompares++; $display("[TB] FAIL rnd_deliver@%0d: got pc=%h ins=%h want pc=%h ins=%h", cyc, bus.pc_out, bus.instruction, exp_pc, word_at(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         prev_req = bus.mem_read && bus.mem_busywait;
         prev_addr = bus.mem_address;
         step;
      end
      bus.stall = 1'b0;
      bus.branch_taken = 1'b0;
      bus.mem_busywait = 1'b0;
      vectors++; if (bus.fault !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_fault: got %b want 0", bus.fault); end
      vectors++; if (delivered < 100) begin miscompares++; $display("[TB] FAIL rnd_progress: got %0d deliveries want >= 100", delivered); end
   endtask

   initial begin
      test_reset;
      test_sequential;
      test_stall;
      test_branch_busy;
      test_branch_complete;
      test_wrap;
      test_timeout;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset (bits [1:0] ignored).
REQ-002 SHALL have parameter TIMEOUT, default 8'd255, meaning the maximum number of consecutive stalled memory cycles before fault.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 MEM_READ  out  1  read request to instruction memory.
REQ-006 MEM_ADDRESS  out  32  word-aligned fetch address ([1:0]=00).
REQ-007 MEM_READDATA  in  32  instruction word from memory.
REQ-008 MEM_BUSYWAIT  in  1  memory busy; request not yet complete.
REQ-009 INS_READY  out  1  INSTRUCTION/PC_OUT valid.
REQ-010 INSTRUCTION  out  32  head-of-buffer instruction.
REQ-011 PC_OUT  out  32  address of INSTRUCTION.
REQ-012 STALL  in  1  CPU cannot accept an instruction this cycle.
REQ-013 BRANCH_TAKEN  in  1  redirect request, single-cycle pulse.
REQ-014 BRANCH_TARGET  in  32  redirect address (bits [1:0] forced to 00).
REQ-015 FAULT  out  1  sticky memory-timeout flag.

Function
REQ-016 Memory completion SHALL be the rising edge with MEM_READ=1 and MEM_BUSYWAIT=0; MEM_READDATA is sampled on that edge.
REQ-017 MEM_ADDRESS SHALL stay stable from request assertion through completion; a request is never withdrawn before completion except on RESET or FAULT.
REQ-018 The controller SHALL hold a 2-entry FIFO of {pc, instr}; INS_READY=1 iff the FIFO is not empty, and INSTRUCTION/PC_OUT show the head.
REQ-019 Pop SHALL occur on an edge with INS_READY=1 and STALL=0.
REQ-020 In state RUN, MEM_READ SHALL be 1 iff FIFO count <2 or a request is in progress.
REQ-021 On a non-discarded completion, {fetch_pc, MEM_READDATA} SHALL be pushed and fetch_pc SHALL advance by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-022 A simultaneous push and pop SHALL leave count unchanged; a completion cannot occur with count=2, because MEM_READ is low at that count.
REQ-023 FSM states SHALL be RUN, DRAIN and HALT.
REQ-024 On BRANCH_TAKEN in RUN, the FIFO SHALL be flushed that edge (no pop counted) and fetch_pc SHALL be set to {BRANCH_TARGET[31:2],2'b00}.
REQ-025 If a request is in flight without completing on that edge, the state SHALL go to DRAIN.
REQ-026 DRAIN SHALL keep MEM_READ=1 at the old address, discard its completion, then go to RUN and request the target on the next cycle.
REQ-027 BRANCH_TAKEN coincident with completion SHALL discard that data, stay in RUN and request the target next cycle.
REQ-028 BRANCH_TAKEN during DRAIN SHALL update the target only; the latest redirect wins.
REQ-029 In DRAIN, INS_READY SHALL be 0.
REQ-030 A wait counter SHALL count consecutive edges with MEM_READ=1 and MEM_BUSYWAIT=1, and SHALL clear on completion.
REQ-031 When the wait counter reaches TIMEOUT, FAULT SHALL be set to 1 and the state SHALL go to HALT.
REQ-032 HALT SHALL hold MEM_READ=0 and INS_READY=0, ignore BRANCH_TAKEN, and be left only by RESET.
REQ-033 Fetch-to-INS_READY latency SHALL be completion edge +0: the pushed entry is visible in the cycle after the completion edge.

Reset
REQ-034 RESET=1 at an edge SHALL produce: state RUN, fetch_pc=RESET_PC, FIFO empty, wait counter 0, FAULT=0, INS_READY=0, INSTRUCTION=0, PC_OUT=0.
REQ-035 In the cycle after reset, MEM_READ=1 and MEM_ADDRESS=RESET_PC.
REQ-036 RESET SHALL override all other inputs, including mid-request, DRAIN and HALT; any in-flight completion is abandoned.

Verification
REQ-037 Reset, zero-wait memory returning 0x00900093/0x00500113/0x00208333, STALL=0 -> PC_OUT 0,4,8 on consecutive cycles; INSTRUCTION matches each word.
REQ-038 STALL=1 held for 5 cycles -> exactly 2 entries are buffered and MEM_READ drops to 0; after STALL is released, 0x0/0x4 are delivered, then fetch resumes at 0x8.
REQ-039 BRANCH_TAKEN with target 0x22 while the request at 0x10 is busy for 3 cycles -> the 0x10 data is never delivered, next MEM_ADDRESS is 0x20, and the first PC_OUT after the branch is 0x20.
REQ-040 BRANCH_TAKEN on the completion edge of 0x8 with target 0x40 -> the 0x8 data is dropped and the next request is 0x40.
REQ-041 MEM_BUSYWAIT stuck high with TIMEOUT=4 -> FAULT=1 after 4 stalled edges, and MEM_READ=0 and INS_READY=0 thereafter; a subsequent RESET clears FAULT and restarts at RESET_PC.
REQ-042 fetch_pc=0xFFFFFFFC completes -> next MEM_ADDRESS is 0x00000000.
